uart_tx_fifo: RTL and testbench

- UART transmitter with a small input FIFO. It is the transmit-side counterpart of the team's 8N1 UART receiver and shares its baud-rate parameterisation.
- Serialises bytes LSB-first: 1 start bit (0), 8 data bits, STOP_BITS stop bits (1).
- The motor-control logic pushes command/telemetry bytes via a valid/ready handshake. Buffering lets short bursts go out back-to-back without stalling the producer.

---
 rtl/uart_tx_fifo.sv | 218 +++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1/8N2, LSB first) fed by a small circular byte FIFO.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
`timescale 1ns/1ps

module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic                         i_Clock,
  input  logic                         i_Reset,
  input  logic                         i_Tx_DV,
  input  logic [7:0]                   i_Tx_Byte,
  output logic                         o_Tx_Ready,
  output logic                         o_Tx_Serial,
  output logic                         o_Tx_Active,
  output logic                         o_Tx_Done,
  output logic [$clog2(FIFO_DEPTH):0]  o_Fifo_Count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  // Sized for the longest phase (the stop period), so 5208 and 2 stop bits both fit.
  localparam int CLK_W = $clog2(CLKS_PER_BIT * STOP_BITS);

  localparam logic [CLK_W-1:0] BIT_LAST   = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [CLK_W-1:0] STOP_LAST  = CLK_W'(CLKS_PER_BIT * STOP_BITS - 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY  = 3'd3,
`endif
    S_STOP    = 3'd4,
    S_CLEANUP = 3'd5
  } state_t;

  // FIFO
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_n;
  logic             push;
  logic             pop;

  // Registered ready is low whenever count is full, so a write racing a pop is rejected.
  assign push         = i_Tx_DV && o_Tx_Ready;
  assign o_Fifo_Count = count;

  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_Tx_Ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count      <= count_n;
      o_Tx_Ready <= (count_n != FULL_COUNT);
    end
  end

  // NOTE: storage array has no reset; occupancy is tracked by count, so stale entries are never read.
  always_ff @(posedge i_Clock) begin
    if (push) mem[wr_ptr] <= i_Tx_Byte;
  end

  // Transmit FSM
  state_t           state;
  state_t           state_n;
  logic [CLK_W-1:0] clk_cnt;
  logic [CLK_W-1:0] clk_cnt_n;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_n;
  logic [7:0]       shift;
  logic [7:0]       shift_n;
  logic             serial_n;
  logic             active_n;
  logic             done_n;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    pop       = 1'b0;

    case (state)
      S_IDLE: begin
        clk_cnt_n = '0;
        bit_idx_n = '0;
        if (count != '0) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = S_START;
        end
      end
      S_START: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_n = '0;
          bit_idx_n = '0;
          state_n   = S_DATA;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_n = '0;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            bit_idx_n = bit_idx + 1'b1;
          end
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_n = '0;
          state_n   = S_STOP;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (clk_cnt == STOP_LAST) begin
          clk_cnt_n = '0;
          state_n   = S_CLEANUP;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      S_CLEANUP: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n   = S_IDLE;
        clk_cnt_n = '0;
        bit_idx_n = '0;
      end
    endcase

    // Outputs are decoded from the next state and registered, so the line never glitches.
    serial_n = 1'b1;
    active_n = 1'b0;
    done_n   = 1'b0;
    case (state_n)
      S_START: begin
        serial_n = 1'b0;
        active_n = 1'b1;
      end
      S_DATA: begin
        serial_n = shift_n[bit_idx_n];
        active_n = 1'b1;
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        serial_n = ^shift_n;
        active_n = 1'b1;
      end
`endif
      S_STOP: begin
        active_n = 1'b1;
      end
      S_CLEANUP: begin
        done_n = 1'b1;
      end
      default: begin
        serial_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state       <= S_IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      state       <= state_n;
      clk_cnt     <= clk_cnt_n;
      bit_idx     <= bit_idx_n;
      shift       <= shift_n;
      o_Tx_Serial <= serial_n;
      o_Tx_Active <= active_n;
      o_Tx_Done   <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: timestamp/queue reference model plus a line decoder.
`timescale 1ns/1ps

module tb_uart_tx_fifo;

  localparam int C     = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int F1 = (9 + PAR + 1) * C;
  localparam int F2 = (9 + PAR + 2) * C;

  logic          i_Clock;
  logic          i_Reset;
  logic          i_Tx_DV;
  logic [7:0]    i_Tx_Byte;
  logic          o_Tx_Ready;
  logic          o_Tx_Serial;
  logic          o_Tx_Active;
  logic          o_Tx_Done;
  logic [CW-1:0] o_Fifo_Count;

  logic          dv2;
  logic [7:0]    byte2;
  logic          rdy2;
  logic          ser2;
  logic          act2;
  logic          done2;
  logic [CW-1:0] cnt2;

  uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Tx_DV(i_Tx_DV), .i_Tx_Byte(i_Tx_Byte),
    .o_Tx_Ready(o_Tx_Ready), .o_Tx_Serial(o_Tx_Serial), .o_Tx_Active(o_Tx_Active),
    .o_Tx_Done(o_Tx_Done), .o_Fifo_Count(o_Fifo_Count)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut2 (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Tx_DV(dv2), .i_Tx_Byte(byte2),
    .o_Tx_Ready(rdy2), .o_Tx_Serial(ser2), .o_Tx_Active(act2),
    .o_Tx_Done(done2), .o_Fifo_Count(cnt2)
  );

  initial begin
    i_Clock = 1'b0;
    forever #5 i_Clock = ~i_Clock;
  end

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of buffered bytes, frame start timestamp, earliest next pop edge.
  logic [7:0] q_m[$];
  logic [7:0] pop_log[$];
  logic [7:0] rx_q[$];
  int         e_m;
  int         f_start;
  logic [7:0] f_byte;
  int         pop_ok;
  logic       rdy_m;
  logic [6:0] exp_b;
  logic [6:0] obs_b;

  function automatic logic line_bit(input logic [7:0] b, input int off);
    int k;
    k = off / C;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (PAR == 1 && k == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic model_reset();
    q_m.delete();
    pop_log.delete();
    f_start = -1;
    f_byte  = '0;
    pop_ok  = 0;
    rdy_m   = 1'b1;
  endtask

  task automatic model_edge(input logic dv, input logic [7:0] b);
    bit   do_pop;
    bit   do_push;
    int   off;
    logic ser;
    logic act;
    logic dn;
    do_pop  = (e_m >= pop_ok) && (q_m.size() > 0);
    do_push = dv && rdy_m;
    if (do_pop) begin
      f_byte  = q_m.pop_front();
      f_start = e_m;
      pop_ok  = e_m + F1 + 2;
      pop_log.push_back(f_byte);
    end
    if (do_push) q_m.push_back(b);
    rdy_m = (q_m.size() < DEPTH);
    off   = e_m - f_start;
    act   = (f_start >= 0) && (off < F1);
    ser   = act ? line_bit(f_byte, off) : 1'b1;
    dn    = (f_start >= 0) && (off == F1);
    exp_b = {ser, act, dn, rdy_m, CW'(q_m.size())};
    e_m++;
  endtask

  task automatic step(input logic dv, input logic [7:0] b);
    i_Tx_DV   = dv;
    i_Tx_Byte = b;
    @(posedge i_Clock);
    model_edge(dv, b);
    @(negedge i_Clock);
    i_Tx_DV = 1'b0;
    obs_b   = {o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Tx_Ready, o_Fifo_Count};
  endtask

  // Line decoder: samples each bit mid-period from the falling start edge.
  initial begin
    int         cnt;
    bit         busy;
    logic [7:0] sh;
    busy = 1'b0;
    cnt  = 0;
    sh   = '0;
    forever begin
      @(negedge i_Clock);
      if (i_Reset) begin
        busy = 1'b0;
      end else if (!busy) begin
        if (o_Tx_Serial === 1'b0) begin
          busy = 1'b1;
          cnt  = 0;
        end
      end else begin
        cnt++;
        if ((cnt % C) == (C / 2) && (cnt / C) >= 1 && (cnt / C) <= 8)
          sh[cnt/C-1] = o_Tx_Serial;
        if (cnt == (9 + PAR) * C + C / 2) begin
          if (o_Tx_Serial === 1'b1) rx_q.push_back(sh);
          busy = 1'b0;
        end
      end
    end
  end

  task automatic test_reset();
    i_Reset = 1'b1;
    #1;
    checks++;
    if ({o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Tx_Ready, o_Fifo_Count} !== 7'b1001000) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b",
               {o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Tx_Ready, o_Fifo_Count}, 7'b1001000);
    end
    @(negedge i_Clock);
    @(negedge i_Clock);
    i_Reset = 1'b0;
    model_reset();
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 8'($urandom));
      checks++;
      if (obs_b !== exp_b) begin
        failures++;
        $display("FAIL idle cycle=%0d got=%b exp=%b", i, obs_b, exp_b);
      end
    end
  endtask

  task automatic test_single();
    int act_cycles;
    int done_cnt;
    int done_at;
    act_cycles = 0;
    done_cnt   = 0;
    done_at    = -1;
    rx_q.delete();
    pop_log.delete();
    step(1'b1, 8'hA5);
    for (int i = 1; i <= F1 + 6; i++) begin
      step(1'b0, 8'h00);
      if (o_Tx_Active) act_cycles++;
      if (o_Tx_Done) begin
        done_cnt++;
        done_at = i;
      end
      checks++;
      if (obs_b !== exp_b) begin
        failures++;
        $display("FAIL single cycle=%0d got=%b exp=%b", i, obs_b, exp_b);
      end
    end
    checks++;
    if (act_cycles != F1) begin
      failures++;
      $display("FAIL single_active_len got=%0d exp=%0d", act_cycles, F1);
    end
    checks++;
    if (done_cnt != 1 || done_at != F1 + 1) begin
      failures++;
      $display("FAIL single_done got_count=%0d got_at=%0d exp_count=1 exp_at=%0d",
               done_cnt, done_at, F1 + 1);
    end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
      failures++;
      $display("FAIL single_rx got_size=%0d exp_size=1 exp=a5", rx_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [5];
    int done_cnt;
    bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03; bytes[3] = 8'h04; bytes[4] = 8'h55;
    done_cnt = 0;
    rx_q.delete();
    pop_log.delete();
    for (int i = 0; i < 5 * (F1 + 2) + 20; i++) begin
      if (i < 5) step(1'b1, bytes[i]);
      else       step(1'b0, 8'h00);
      if (o_Tx_Done) done_cnt++;
      checks++;
      if (obs_b !== exp_b) begin
        failures++;
        $display("FAIL burst cycle=%0d got=%b exp=%b", i, obs_b, exp_b);
      end
    end
    checks++;
    if (done_cnt != 5) begin
      failures++;
      $display("FAIL burst_done got=%0d exp=5", done_cnt);
    end
    checks++;
    if (rx_q.size() != 5) begin
      failures++;
      $display("FAIL burst_rx_count got=%0d exp=5", rx_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (rx_q[i] !== bytes[i]) begin
          failures++;
          $display("FAIL burst_rx idx=%0d got=%h exp=%h", i, rx_q[i], bytes[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] bytes [5];
    rx_q.delete();
    pop_log.delete();
    for (int i = 0; i < 5; i++) bytes[i] = 8'($urandom_range(0, 254));
    for (int i = 0; i < 8; i++) begin
      if (i < 5) step(1'b1, bytes[i]);
      else       step(1'b1, 8'hFF);
      checks++;
      if (obs_b !== exp_b) begin
        failures++;
        $display("FAIL overflow_fill cycle=%0d got=%b exp=%b", i, obs_b, exp_b);
      end
    end
    checks++;
    if (o_Fifo_Count !== 3'd4 || o_Tx_Ready !== 1'b0) begin
      failures++;
      $display("FAIL overflow_full got_count=%0d got_ready=%b exp_count=4 exp_ready=0",
               o_Fifo_Count, o_Tx_Ready);
    end
    for (int i = 0; i < 5 * (F1 + 2) + 20; i++) begin
      step(1'b0, 8'h00);
      checks++;
      if (obs_b !== exp_b) begin
        failures++;
        $display("FAIL overflow_drain cycle=%0d got=%b exp=%b", i, obs_b, exp_b);
      end
    end
    checks++;
    if (rx_q.size() != 5) begin
      failures++;
      $display("FAIL overflow_rx_count got=%0d exp=5", rx_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (rx_q[i] !== bytes[i]) begin
          failures++;
          $display("FAIL overflow_rx idx=%0d got=%h exp=%h", i, rx_q[i], bytes[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    rx_q.delete();
    pop_log.delete();
    for (int i = 0; i < 2500 + 6 * (F1 + 2); i++) begin
      if (i < 2500) step(($urandom_range(0, 15) == 0), 8'($urandom));
      else          step(1'b0, 8'h00);
      checks++;
      if (obs_b !== exp_b) begin
        failures++;
        $display("FAIL random cycle=%0d got=%b exp=%b", i, obs_b, exp_b);
      end
    end
    checks++;
    if (rx_q.size() != pop_log.size()) begin
      failures++;
      $display("FAIL random_rx_count got=%0d exp=%0d", rx_q.size(), pop_log.size());
    end else begin
      for (int i = 0; i < rx_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== pop_log[i]) begin
          failures++;
          $display("FAIL random_rx idx=%0d got=%h exp=%h", i, rx_q[i], pop_log[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    step(1'b1, 8'h3C);
    step(1'b1, 8'($urandom));
    step(1'b1, 8'($urandom));
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 8'h00);
      checks++;
      if (obs_b !== exp_b) begin
        failures++;
        $display("FAIL pre_reset cycle=%0d got=%b exp=%b", i, obs_b, exp_b);
      end
    end
    checks++;
    if (o_Fifo_Count !== 3'd2 || o_Tx_Active !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_state got_count=%0d got_active=%b exp_count=2 exp_active=1",
               o_Fifo_Count, o_Tx_Active);
    end
    #2;
    i_Reset = 1'b1;
    #1;
    checks++;
    if ({o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Tx_Ready, o_Fifo_Count} !== 7'b1001000) begin
      failures++;
      $display("FAIL mid_reset got=%b exp=%b",
               {o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Tx_Ready, o_Fifo_Count}, 7'b1001000);
    end
    @(negedge i_Clock);
    @(negedge i_Clock);
    i_Reset = 1'b0;
    model_reset();
    rx_q.delete();
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 8'h00);
      checks++;
      if (obs_b !== exp_b) begin
        failures++;
        $display("FAIL post_reset cycle=%0d got=%b exp=%b", i, obs_b, exp_b);
      end
    end
    checks++;
    if (rx_q.size() != 0) begin
      failures++;
      $display("FAIL post_reset_rx got=%0d exp=0", rx_q.size());
    end
  endtask

  task automatic test_two_stop();
    logic [7:0] b;
    int         act_cycles;
    logic [6:0] got;
    logic [6:0] want;
    for (int t = 0; t < 2; t++) begin
      b = (t == 0) ? 8'h07 : 8'($urandom);
      act_cycles = 0;
      dv2   = 1'b1;
      byte2 = b;
      @(posedge i_Clock);
      @(negedge i_Clock);
      dv2 = 1'b0;
      for (int n = 0; n <= F2 + 3; n++) begin
        @(posedge i_Clock);
        @(negedge i_Clock);
        if (act2) act_cycles++;
        got  = {ser2, act2, done2, rdy2, cnt2};
        want = {(n < F2) ? line_bit(b, n) : 1'b1, (n < F2), (n == F2), 1'b1, 3'd0};
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL two_stop byte=%h off=%0d got=%b exp=%b", b, n, got, want);
        end
      end
      checks++;
      if (act_cycles != F2) begin
        failures++;
        $display("FAIL two_stop_len got=%0d exp=%0d", act_cycles, F2);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_Reset   = 1'b1;
    i_Tx_DV   = 1'b0;
    i_Tx_Byte = '0;
    dv2       = 1'b0;
    byte2     = '0;
    e_m       = 0;
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_random();
    test_reset_mid_frame();
    test_two_stop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
